// File: rtl/quiz_pkg.sv
// Shared types and helpers for the buzzer quiz round controller.
package quiz_pkg;

  localparam int N_PLAYERS = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    LOCKED  = 3'd2,
    TIMEOUT = 3'd3,
    FOUL    = 3'd4
  } quiz_state_t;

  // Winner display: hundreds digit is the 1-based contestant, low digits the frozen seconds.
  function automatic logic [9:0] display_value(input logic [1:0] id, input logic [6:0] sec);
    return (10'(id) + 10'd1) * 10'd100 + 10'(sec);
  endfunction

endpackage

// File: rtl/quiz_controller_btn_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-flop synchronizer, optional
// counter debouncer (QUIZ_DEBOUNCE_EN), rising-edge detect with registered pulse.
module btn_conditioner
  import quiz_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_press
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_press;
  logic       w_level;

  if (DEBOUNCE_CYC < 1) begin : g_bad_cfg
    $error("btn_conditioner: DEBOUNCE_CYC must be at least 1");
  end

  // Everything resets "high" so a button held through reset never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

`ifdef QUIZ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic          r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else if (r_sync[1] == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
      r_stable <= r_sync[1];
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_press <= w_level & ~r_prev;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/quiz_controller.sv
// Buzzer quiz round controller: start/countdown/first-press lock-out/foul, with
// registered display value for the 3-digit scan driver. Optional QUIZ_DEBOUNCE_EN.
module quiz_controller
  import quiz_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int COUNT_SEC    = 30,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       host_start,
  input  logic       host_clear,
  input  logic [3:0] btn,
  output logic [9:0] DataIn,
  output logic       ErrorFlag,
  output logic       winner_valid,
  output logic [1:0] winner_id,
  output logic [3:0] led,
  output logic [2:0] round_state
);

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [6:0]      SEC_INIT  = 7'(COUNT_SEC);

  logic [N_PLAYERS-1:0] w_btn_press;
  logic                 w_start_press;
  logic                 w_clear_press;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
    .clk(clk_50M), .rst_n(rst_n), .i_raw(host_start), .o_press(w_start_press)
  );

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
    .clk(clk_50M), .rst_n(rst_n), .i_raw(host_clear), .o_press(w_clear_press)
  );

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_btn
    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
      .clk(clk_50M), .rst_n(rst_n), .i_raw(btn[g]), .o_press(w_btn_press[g])
    );
  end

  quiz_state_t   r_state, w_state_nxt;
  logic [6:0]    r_sec, w_sec_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [1:0]    r_id, w_id_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_err, w_err_nxt;
  logic [9:0]    r_data, w_data_nxt;
  logic [3:0]    r_led, w_led_nxt;
  logic [1:0]    w_first_id;
  logic          w_any_btn;

  // Lowest index wins when several contestants press in the same cycle.
  always_comb begin
    w_first_id = 2'd0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (w_btn_press[i]) w_first_id = 2'(i);
    end
  end

  assign w_any_btn = |w_btn_press;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sec   <= SEC_INIT;
      r_presc <= '0;
      r_id    <= 2'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= 10'(COUNT_SEC);
      r_led   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sec   <= w_sec_nxt;
      r_presc <= w_presc_nxt;
      r_id    <= w_id_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_data  <= w_data_nxt;
      r_led   <= w_led_nxt;
    end
  end

  // Priority per cycle: clear > contestant press > tick > start.
  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_presc_nxt = r_presc;
    w_id_nxt    = r_id;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    if (w_clear_press) begin
      w_state_nxt = IDLE;
      w_sec_nxt   = SEC_INIT;
      w_presc_nxt = '0;
      w_id_nxt    = 2'd0;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_btn) begin
            w_state_nxt = FOUL;
            w_id_nxt    = w_first_id;
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (w_start_press) begin
            w_state_nxt = ARMED;
            w_sec_nxt   = SEC_INIT;
            w_presc_nxt = '0;
          end
        end
        ARMED: begin
          if (w_any_btn) begin
            w_state_nxt = LOCKED;
            w_id_nxt    = w_first_id;
            w_valid_nxt = 1'b1;
          end else if (r_presc == PRESC_MAX) begin
            w_presc_nxt = '0;
            if (r_sec <= 7'd1) begin
              w_state_nxt = TIMEOUT;
              w_sec_nxt   = 7'd0;
            end else begin
              w_sec_nxt = r_sec - 7'd1;
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Display and lamp values are derived from the next state so they register alongside it.
  always_comb begin
    w_data_nxt = 10'(COUNT_SEC);
    case (w_state_nxt)
      IDLE:    w_data_nxt = 10'(COUNT_SEC);
      ARMED:   w_data_nxt = 10'(w_sec_nxt);
      LOCKED:  w_data_nxt = display_value(w_id_nxt, w_sec_nxt);
      TIMEOUT: w_data_nxt = 10'd0;
      FOUL:    w_data_nxt = 10'(w_id_nxt) + 10'd1;
      default: w_data_nxt = 10'(COUNT_SEC);
    endcase
    w_led_nxt = w_valid_nxt ? (4'b0001 << w_id_nxt) : 4'b0000;
  end

  assign DataIn       = r_data;
  assign ErrorFlag    = r_err;
  assign winner_valid = r_valid;
  assign winner_id    = r_id;
  assign led          = r_led;
  assign round_state  = r_state;

endmodule

// File: tb/tb_quiz_controller.sv
// Directed bench for quiz_controller (CLK_HZ=10, COUNT_SEC=3, DEBOUNCE_CYC=4);
// adapts press latency when QUIZ_DEBOUNCE_EN is defined.
module tb_quiz_controller;
  import quiz_pkg::*;

  localparam int DC = 4;
`ifdef QUIZ_DEBOUNCE_EN
  localparam int LAT = DC + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       host_start;
  logic       host_clear;
  logic [3:0] btn;
  logic [9:0] DataIn;
  logic       ErrorFlag;
  logic       winner_valid;
  logic [1:0] winner_id;
  logic [3:0] led;
  logic [2:0] round_state;

  int n_cmp = 0;
  int n_bad = 0;

  quiz_controller #(.CLK_HZ(10), .COUNT_SEC(3), .DEBOUNCE_CYC(DC)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .host_start(host_start), .host_clear(host_clear),
    .btn(btn), .DataIn(DataIn), .ErrorFlag(ErrorFlag), .winner_valid(winner_valid),
    .winner_id(winner_id), .led(led), .round_state(round_state)
  );

  // clock / reset
  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input quiz_state_t st, input int data,
                           input logic err, input logic vld, input int id, input int ld);
    check({tag, ".state"}, 32'(round_state), 32'(st));
    check({tag, ".data"}, 32'(DataIn), 32'(data));
    check({tag, ".err"}, 32'(ErrorFlag), 32'(err));
    check({tag, ".valid"}, 32'(winner_valid), 32'(vld));
    check({tag, ".id"}, 32'(winner_id), 32'(id));
    check({tag, ".led"}, 32'(led), 32'(ld));
  endtask

  // Raise the raw inputs just before edge k; returns at the negedge after edge k+LAT, then releases.
  task automatic press(input logic [3:0] b, input logic s, input logic c);
    @(posedge clk_50M); #1;
    btn = b; host_start = s; host_clear = c;
    repeat (LAT + 1) @(posedge clk_50M);
    @(negedge clk_50M);
    btn = 4'd0; host_start = 1'b0; host_clear = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk_50M);
    @(negedge clk_50M);
  endtask

  initial begin
    rst_n = 1'b0; host_start = 1'b0; host_clear = 1'b0; btn = 4'd0;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    rst_n = 1'b1;

    // reset then idle
    check_all("reset", IDLE, 3, 1'b0, 1'b0, 0, 0);
    settle(100);
    check_all("idle100", IDLE, 3, 1'b0, 1'b0, 0, 0);

    // countdown to timeout
    press(4'd0, 1'b1, 1'b0);
    check_all("armed", ARMED, 3, 1'b0, 1'b0, 0, 0);
    repeat (9) @(posedge clk_50M); @(negedge clk_50M);
    check("tick9.data", 32'(DataIn), 32'd3);
    repeat (1) @(posedge clk_50M); @(negedge clk_50M);
    check("tick10.data", 32'(DataIn), 32'd2);
    repeat (10) @(posedge clk_50M); @(negedge clk_50M);
    check("tick20.data", 32'(DataIn), 32'd1);
    repeat (10) @(posedge clk_50M); @(negedge clk_50M);
    check_all("timeout", TIMEOUT, 0, 1'b0, 1'b0, 0, 0);
    settle(DC + 2);
    press(4'b0010, 1'b0, 1'b0);
    check_all("timeout_btn1", TIMEOUT, 0, 1'b0, 1'b0, 0, 0);
    press(4'd0, 1'b0, 1'b1);
    check_all("clear1", IDLE, 3, 1'b0, 1'b0, 0, 0);
    settle(DC + 2);

    // btn[2] lands 17 cycles into ARMED, seconds = 2
    press(4'd0, 1'b1, 1'b0);
    repeat (15 - LAT) @(posedge clk_50M);
    press(4'b0100, 1'b0, 1'b0);
    check_all("lock2", LOCKED, 302, 1'b0, 1'b1, 2, 4'b0100);
    settle(20);
    check("lock2.frozen", 32'(DataIn), 32'd302);
    press(4'b0001, 1'b0, 1'b0);
    check_all("lock2_btn0", LOCKED, 302, 1'b0, 1'b1, 2, 4'b0100);
    press(4'd0, 1'b0, 1'b1);
    settle(DC + 2);

    // foul in idle
    press(4'b1000, 1'b0, 1'b0);
    check_all("foul3", FOUL, 4, 1'b1, 1'b1, 3, 4'b1000);
    settle(DC + 2);
    press(4'd0, 1'b1, 1'b0);
    check_all("foul3_start", FOUL, 4, 1'b1, 1'b1, 3, 4'b1000);
    settle(DC + 2);
    press(4'd0, 1'b0, 1'b1);
    check_all("clear_foul", IDLE, 3, 1'b0, 1'b0, 0, 0);
    settle(DC + 2);

    // simultaneous presses: lowest index wins
    press(4'd0, 1'b1, 1'b0);
    press(4'b0011, 1'b0, 1'b0);
    check_all("tie01", LOCKED, 103, 1'b0, 1'b1, 0, 4'b0001);
    settle(DC + 2);
    press(4'd0, 1'b0, 1'b1);
    settle(DC + 2);

    // press coincident with the final tick
    press(4'd0, 1'b1, 1'b0);
    repeat (28 - LAT) @(posedge clk_50M);
    press(4'b0001, 1'b0, 1'b0);
    check_all("final_tick", LOCKED, 101, 1'b0, 1'b1, 0, 4'b0001);

    // asynchronous reset mid-round, with btn[1] held through it
    btn = 4'b0010;
    @(negedge clk_50M); #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", IDLE, 3, 1'b0, 1'b0, 0, 0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    settle(LAT + 10);
    check_all("held_rst", IDLE, 3, 1'b0, 1'b0, 0, 0);
    btn = 4'd0;
    settle(DC + 4);

`ifdef QUIZ_DEBOUNCE_EN
    @(posedge clk_50M); #1; btn = 4'b0010;
    repeat (3) @(posedge clk_50M); #1; btn = 4'd0;
    settle(LAT + 8);
    check_all("glitch3", IDLE, 3, 1'b0, 1'b0, 0, 0);
    @(posedge clk_50M); #1; btn = 4'b0010;
    repeat (6) @(posedge clk_50M); #1; btn = 4'd0;
    settle(LAT + 8);
    check_all("pulse6", FOUL, 2, 1'b1, 1'b1, 1, 4'b0010);
`else
    @(posedge clk_50M); #1; btn = 4'b0010;
    @(posedge clk_50M); #1; btn = 4'd0;
    settle(LAT + 4);
    check_all("pulse1", FOUL, 2, 1'b1, 1'b1, 1, 4'b0010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
